// File: rtl/fixed_act_requant.sv
// Requantiser feeding LUT-based activations: round-half-up, saturate, then a 2-entry skid buffer.
// Optional `SAT_CNT_EN adds a sticky saturated-element counter on port sat_count.
module fixed_act_requant #(
  parameter int DATA_IN_0_PRECISION_0       = 16,
  parameter int DATA_IN_0_PRECISION_1       = 8,
  parameter int DATA_OUT_0_PRECISION_0      = 8,
  parameter int DATA_OUT_0_PRECISION_1      = 4,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 10,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_1 = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
  parameter int SAT_CNT_WIDTH               = 16
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic signed [DATA_IN_0_PRECISION_0-1:0]  data_in_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1],
  input  logic                                     data_in_0_valid,
  output logic                                     data_in_0_ready,
  output logic signed [DATA_OUT_0_PRECISION_0-1:0] data_out_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1],
  output logic                                     data_out_0_valid,
  input  logic                                     data_out_0_ready,
  output logic                                     tensor_done
`ifdef SAT_CNT_EN
  ,
  output logic [SAT_CNT_WIDTH-1:0]                 sat_count
`endif
);

  localparam int P     = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
  localparam int IW    = DATA_IN_0_PRECISION_0;
  localparam int OW    = DATA_OUT_0_PRECISION_0;
  localparam int SH    = DATA_IN_0_PRECISION_1 - DATA_OUT_0_PRECISION_1;
  localparam int N     = (DATA_IN_0_TENSOR_SIZE_DIM_0 * DATA_IN_0_TENSOR_SIZE_DIM_1) / P;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic signed [IW:0] RND     = (IW+1)'((2 ** SH) / 2);
  localparam logic signed [IW:0] SAT_MAX = (IW+1)'((2 ** (OW-1)) - 1);
  localparam logic signed [IW:0] SAT_MIN = (IW+1)'(-(2 ** (OW-1)));
  localparam logic [CNT_W-1:0]   LAST    = CNT_W'(N - 1);

  // One guard bit keeps x + half-LSB from overflowing before the shift.
  function automatic logic signed [IW:0] round_shift(input logic signed [IW-1:0] x);
    logic signed [IW:0] sum;
    sum = {x[IW-1], x} + RND;
    return sum >>> SH;
  endfunction

  function automatic logic signed [OW-1:0] saturate(input logic signed [IW:0] r);
    logic signed [OW-1:0] res;
    res = r[OW-1:0];
    if (r > SAT_MAX)      res = SAT_MAX[OW-1:0];
    else if (r < SAT_MIN) res = SAT_MIN[OW-1:0];
    return res;
  endfunction

  function automatic logic is_clamped(input logic signed [IW:0] r);
    return (r > SAT_MAX) || (r < SAT_MIN);
  endfunction

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t               state, state_nxt;
  logic                 ready_q;
  logic                 in_hs, out_hs;
  logic                 load_m, load_s, m_from_s;
  logic [CNT_W-1:0]     beat_cnt;
  logic signed [OW-1:0] q_p0     [P];
  logic signed [OW-1:0] m_data_p1 [P];
  logic signed [OW-1:0] s_data_p1 [P];

  // ---- p0: requantise the incoming beat combinationally ----
  always_comb begin
    for (int p = 0; p < P; p++) begin
      q_p0[p] = saturate(round_shift(data_in_0[p]));
    end
  end

  assign in_hs            = data_in_0_valid && ready_q;
  assign out_hs           = data_out_0_valid && data_out_0_ready;
  assign data_in_0_ready  = ready_q;
  assign data_out_0_valid = (state != EMPTY);
  assign data_out_0       = m_data_p1;
  assign tensor_done      = rst && out_hs && (beat_cnt == LAST);

  always_comb begin
    state_nxt = state;
    load_m    = 1'b0;
    load_s    = 1'b0;
    m_from_s  = 1'b0;
    case (state)
      EMPTY: if (in_hs) begin
        state_nxt = ONE;
        load_m    = 1'b1;
      end
      ONE: begin
        if (in_hs && out_hs) begin
          load_m = 1'b1;
        end else if (in_hs) begin
          state_nxt = TWO;
          load_s    = 1'b1;
        end else if (out_hs) begin
          state_nxt = EMPTY;
        end
      end
      TWO: if (out_hs) begin
        state_nxt = ONE;
        m_from_s  = 1'b1;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // ---- p1: skid buffer registers (M drives the output, S absorbs one stalled beat) ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= EMPTY;
      ready_q  <= 1'b1;
      beat_cnt <= '0;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt != TWO);
      if (out_hs) beat_cnt <= (beat_cnt == LAST) ? '0 : beat_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      m_data_p1 <= '{default: '0};
    end else if (load_m) begin
      m_data_p1 <= q_p0;
    end else if (m_from_s) begin
      m_data_p1 <= s_data_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (load_s) s_data_p1 <= q_p0;
  end

`ifdef SAT_CNT_EN
  logic [SAT_CNT_WIDTH:0]   sat_sum;
  logic [SAT_CNT_WIDTH-1:0] sat_cnt_q;

  always_comb begin
    sat_sum = {1'b0, sat_cnt_q};
    for (int p = 0; p < P; p++) begin
      sat_sum = sat_sum + (SAT_CNT_WIDTH+1)'(is_clamped(round_shift(data_in_0[p])));
    end
  end

  // Carry out of the add means the counter has hit its ceiling; hold all-ones.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sat_cnt_q <= '0;
    end else if (in_hs) begin
      sat_cnt_q <= sat_sum[SAT_CNT_WIDTH] ? '1 : sat_sum[SAT_CNT_WIDTH-1:0];
    end
  end

  assign sat_count = sat_cnt_q;
`endif

endmodule

// File: tb/tb_fixed_act_requant.sv
// Directed bench for fixed_act_requant at default parameters (SH=4, P=1, N=10).
// Checks sat_count as well when built with `SAT_CNT_EN.
module tb_fixed_act_requant;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic signed [15:0] data_in_0 [1];
  logic              data_in_0_valid = 1'b0;
  logic              data_in_0_ready;
  logic signed [7:0] data_out_0 [1];
  logic              data_out_0_valid;
  logic              data_out_0_ready = 1'b1;
  logic              tensor_done;
  logic [7:0]        out_u;
`ifdef SAT_CNT_EN
  logic [15:0]       sat_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign out_u = data_out_0[0];

  fixed_act_requant dut (
    .clk              (clk),
    .rst              (rst),
    .data_in_0        (data_in_0),
    .data_in_0_valid  (data_in_0_valid),
    .data_in_0_ready  (data_in_0_ready),
    .data_out_0       (data_out_0),
    .data_out_0_valid (data_out_0_valid),
    .data_out_0_ready (data_out_0_ready),
    .tensor_done      (tensor_done)
`ifdef SAT_CNT_EN
    ,
    .sat_count        (sat_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive at the falling edge, then sample 1 time unit later.
  task automatic step(input logic v, input logic [15:0] d, input logic rdy);
    @(negedge clk);
    data_in_0_valid  = v;
    data_in_0[0]     = d;
    data_out_0_ready = rdy;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    data_in_0_valid = 1'b0;
    data_out_0_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_valid", 32'(data_out_0_valid), 32'd0);
    chk("rst_ready", 32'(data_in_0_ready), 32'd1);
    chk("rst_data",  32'(out_u), 32'h00);
    chk("rst_done",  32'(tensor_done), 32'd0);
  endtask

  // Single beat into an empty buffer: visible one cycle after the input handshake.
  task automatic send(input string tag, input logic [15:0] x, input logic [7:0] exp);
    step(1'b1, x, 1'b1);
    chk({tag, "_in_ready"}, 32'(data_in_0_ready), 32'd1);
    step(1'b0, 16'h0000, 1'b1);
    chk({tag, "_valid"}, 32'(data_out_0_valid), 32'd1);
    chk(tag, 32'(out_u), 32'(exp));
  endtask

  // n back-to-back beats (beat k carries k<<4 -> k) with ready high.
  task automatic stream(input string tag, input int n);
    for (int cyc = 0; cyc <= n; cyc++) begin
      if (cyc < n) step(1'b1, 16'((cyc + 1) * 16), 1'b1);
      else         step(1'b0, 16'h0000, 1'b1);
      if (cyc >= 1) begin
        chk({tag, "_valid"}, 32'(data_out_0_valid), 32'd1);
        chk({tag, "_data"},  32'(out_u), 32'(cyc));
        chk({tag, "_done"},  32'(tensor_done), 32'((cyc % 10) == 0));
      end
    end
    step(1'b0, 16'h0000, 1'b1);
    chk({tag, "_drain"}, 32'(data_out_0_valid), 32'd0);
  endtask

  initial begin
    data_in_0[0] = 16'h0000;

    // Reset state
    do_reset();

    // Saturation at both rails
    send("sat_pos", 16'h7FFF, 8'h7F);
    send("sat_neg", 16'h8000, 8'h80);
`ifdef SAT_CNT_EN
    chk("sat_count2", 32'(sat_count), 32'd2);
`endif

    // Rounding
    send("r_1p5",   16'h0180, 8'h18);
    send("r_up",    16'h0188, 8'h19);
    send("r_neg",   16'hFE78, 8'hE8);
    send("r_halfn", 16'hFFF8, 8'h00);
    send("r_m1",    16'hFFF7, 8'hFF);

    // Edges of the output range after rounding
    send("b_127",   16'h07F7, 8'h7F);
    send("b_128",   16'h07F8, 8'h7F);
    send("b_m127",  16'hF808, 8'h81);
    send("b_m128",  16'hF807, 8'h80);
    send("b_m129",  16'hF7F7, 8'h80);
`ifdef SAT_CNT_EN
    chk("sat_count4", 32'(sat_count), 32'd4);
`endif

    // Backpressure: 4 beats, output stalled for 3 cycles
    do_reset();
    step(1'b1, 16'h0010, 1'b0);
    chk("bp_rdy0", 32'(data_in_0_ready), 32'd1);
    step(1'b1, 16'h0020, 1'b0);
    chk("bp_rdy1", 32'(data_in_0_ready), 32'd1);
    chk("bp_v1",   32'(data_out_0_valid), 32'd1);
    chk("bp_d1",   32'(out_u), 32'h01);
    step(1'b1, 16'h0030, 1'b0);
    chk("bp_rdy2", 32'(data_in_0_ready), 32'd0);
    chk("bp_d2",   32'(out_u), 32'h01);
    step(1'b1, 16'h0030, 1'b1);
    chk("bp_rdy3", 32'(data_in_0_ready), 32'd0);
    chk("bp_d3",   32'(out_u), 32'h01);
    step(1'b1, 16'h0030, 1'b1);
    chk("bp_rdy4", 32'(data_in_0_ready), 32'd1);
    chk("bp_d4",   32'(out_u), 32'h02);
    step(1'b1, 16'h0040, 1'b1);
    chk("bp_d5",   32'(out_u), 32'h03);
    step(1'b0, 16'h0000, 1'b1);
    chk("bp_v6",   32'(data_out_0_valid), 32'd1);
    chk("bp_d6",   32'(out_u), 32'h04);
    step(1'b0, 16'h0000, 1'b1);
    chk("bp_v7",   32'(data_out_0_valid), 32'd0);

    // Two tensors back to back
    do_reset();
    stream("t20", 20);

    // Reset while holding two beats mid-tensor
    do_reset();
    for (int k = 1; k <= 4; k++) step(1'b1, 16'(k * 16), 1'b1);
    step(1'b1, 16'h0050, 1'b0);
    step(1'b1, 16'h0060, 1'b0);
    chk("mr_two_rdy", 32'(data_in_0_ready), 32'd0);
    chk("mr_two_d",   32'(out_u), 32'h04);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    data_in_0_valid = 1'b0;
    data_out_0_ready = 1'b1;
    #1;
    chk("mr_valid", 32'(data_out_0_valid), 32'd0);
    chk("mr_ready", 32'(data_in_0_ready), 32'd1);
    chk("mr_data",  32'(out_u), 32'h00);
    chk("mr_done",  32'(tensor_done), 32'd0);
    stream("t10", 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
